// File: rtl/boot_mem_pkg.sv
// Shared types and default configuration for the boot_mem store.
package boot_mem_pkg;

  localparam int unsigned BOOT_DEPTH_DEFAULT     = 16;
  localparam int unsigned BOOT_WIDTH_DEFAULT     = 16;
  localparam int unsigned BOOT_ROM_WORDS_DEFAULT = 7;

  // Word 0 sits in the LSBs.
  localparam logic [BOOT_ROM_WORDS_DEFAULT*BOOT_WIDTH_DEFAULT-1:0] BOOT_IMG_DEFAULT =
    {16'h4000, 16'h3007, 16'hF400, 16'h1007, 16'hF800, 16'h4000, 16'hF200};

  typedef enum logic {
    ST_IDLE,
    ST_SCRUB
  } scrub_state_t;

endpackage

// File: rtl/boot_mem_scrubber.sv
// Scrub engine: walks the RAM region from ROM_WORDS to DEPTH-1 issuing zero writes.
module boot_mem_scrubber
  import boot_mem_pkg::*;
#(
  parameter int unsigned DEPTH     = BOOT_DEPTH_DEFAULT,
  parameter int unsigned ROM_WORDS = BOOT_ROM_WORDS_DEFAULT,
  localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scrub_req,
  input  logic              locked,
  output logic              busy,
  output logic              zero_we,
  output logic [ADDR_W-1:0] zero_addr
);

  scrub_state_t      state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (scrub_req && !locked) begin
          state_d = ST_SCRUB;
          ptr_d   = ADDR_W'(ROM_WORDS);
        end
      end
      ST_SCRUB: begin
        // Stop on the last word so the pointer never wraps into the ROM region.
        if (ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q == ST_SCRUB);
  assign zero_we   = (state_q == ST_SCRUB);
  assign zero_addr = ptr_q;

endmodule

// File: rtl/boot_mem.sv
// Boot store: preset read-only low words, writable RAM above, sticky lock and scrub.
// Build option BOOT_MEM_COMB_READ_EN selects a zero-latency combinational read path.
module boot_mem
  import boot_mem_pkg::*;
#(
  parameter int unsigned DEPTH     = BOOT_DEPTH_DEFAULT,
  parameter int unsigned WIDTH     = BOOT_WIDTH_DEFAULT,
  parameter int unsigned ROM_WORDS = BOOT_ROM_WORDS_DEFAULT,
  parameter logic [ROM_WORDS*WIDTH-1:0] INIT_IMAGE = BOOT_IMG_DEFAULT,
  localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  input  logic              lock,
  input  logic              scrub_req,
  output logic              busy,
  output logic              wr_err
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              locked;
  logic              zero_we;
  logic [ADDR_W-1:0] zero_addr;
  logic              in_rom;
  logic              wr_req;
  logic              wr_ok;
  logic              rd_req;

  boot_mem_scrubber #(
    .DEPTH     (DEPTH),
    .ROM_WORDS (ROM_WORDS)
  ) u_scrubber (
    .clk       (clk),
    .rst       (rst),
    .scrub_req (scrub_req),
    .locked    (locked),
    .busy      (busy),
    .zero_we   (zero_we),
    .zero_addr (zero_addr)
  );

  assign in_rom = (addr < ADDR_W'(ROM_WORDS));
  assign wr_req = cs && we;
  assign wr_ok  = wr_req && !busy && !locked && !in_rom;
  assign rd_req = cs && !we && !busy;

  // Scrub and CPU writes never collide: CPU writes are rejected while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (i < ROM_WORDS) mem[i] <= INIT_IMAGE[i*WIDTH +: WIDTH];
        else               mem[i] <= '0;
      end
    end else if (zero_we) begin
      mem[zero_addr] <= '0;
    end else if (wr_ok) begin
      mem[addr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      if (lock) locked <= 1'b1;
      wr_err <= wr_req && !wr_ok;
    end
  end

`ifdef BOOT_MEM_COMB_READ_EN
  assign dout = rd_req ? mem[addr] : '0;
`else
  logic [WIDTH-1:0] dout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         dout_q <= '0;
    else if (rd_req) dout_q <= mem[addr];
  end

  assign dout = dout_q;
`endif

endmodule

// File: tb/tb_boot_mem.sv
// Directed scoreboard bench for boot_mem: read latency, ROM protection, lock, scrub, reset abort.
module tb_boot_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        we;
  logic [3:0]  addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        lock;
  logic        scrub_req;
  logic        busy;
  logic        wr_err;

  int errors = 0;
  int checks = 0;

  logic [15:0] model [16];
  logic [15:0] rom_img [7];
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  boot_mem #(
    .DEPTH     (16),
    .WIDTH     (16),
    .ROM_WORDS (7)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cs        (cs),
    .we        (we),
    .addr      (addr),
    .din       (din),
    .dout      (dout),
    .lock      (lock),
    .scrub_req (scrub_req),
    .busy      (busy),
    .wr_err    (wr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 16; i++) model[i] = (i < 7) ? rom_img[i] : 16'h0000;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [3:0] a);
    logic [15:0] e;
    cs = 1'b1; we = 1'b0; addr = a;
    exp_q.push_back(model[a]);
`ifdef BOOT_MEM_COMB_READ_EN
    #1;
    e = exp_q.pop_front();
    chk($sformatf("comb_rd[%0d]", a), {16'h0, dout}, {16'h0, e});
    step();
    cs = 1'b0;
`else
    step();
    cs = 1'b0;
    e = exp_q.pop_front();
    chk($sformatf("rd[%0d]", a), {16'h0, dout}, {16'h0, e});
`endif
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic exp_err);
    cs = 1'b1; we = 1'b1; addr = a; din = d;
    step();
    cs = 1'b0; we = 1'b0;
    chk($sformatf("wr_err[%0d]", a), {31'h0, wr_err}, {31'h0, exp_err});
    if (!exp_err) model[a] = d;
    step();
    chk($sformatf("wr_err_clr[%0d]", a), {31'h0, wr_err}, 32'h0);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 16; i++) do_read(4'(i));
    chk({tag, "_q_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int n;
    rom_img = '{16'hF200, 16'h4000, 16'hF800, 16'h1007, 16'hF400, 16'h3007, 16'h4000};
    rst = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; din = '0; lock = 1'b0; scrub_req = 1'b0;
    reset_model();
    #1;
    chk("rst_dout", {16'h0, dout}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_wr_err", {31'h0, wr_err}, 32'h0);
    step(); step();
    rst = 1'b0;
    step();

    read_all("init");

    do_write(4'd7, 16'hBEEF, 1'b0);
    do_read(4'd7);
    do_write(4'd3, 16'h1234, 1'b1);
    do_read(4'd3);
    do_write(4'd6, 16'h6666, 1'b1);
    do_read(4'd6);

    for (int i = 7; i < 16; i++) do_write(4'(i), 16'hA5A5, 1'b0);
    do_read(4'd15);
    scrub_req = 1'b1;
    step();
    scrub_req = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      if (n == 2) begin cs = 1'b1; we = 1'b1; addr = 4'd8; din = 16'hFFFF; end
      else begin cs = 1'b0; we = 1'b0; end
      step();
      if (n == 2) chk("wr_err_busy", {31'h0, wr_err}, 32'h1);
      n++;
    end
    cs = 1'b0; we = 1'b0;
    chk("scrub_busy_cycles", n, 9);
    for (int i = 7; i < 16; i++) model[i] = 16'h0000;
    read_all("post_scrub");

    lock = 1'b1;
    do_write(4'd10, 16'h7777, 1'b0);
    lock = 1'b0;
    do_write(4'd9, 16'h5555, 1'b1);
    do_read(4'd9);
    do_read(4'd10);
    scrub_req = 1'b1;
    step();
    scrub_req = 1'b0;
    chk("lock_scrub_busy0", {31'h0, busy}, 32'h0);
    step();
    chk("lock_scrub_busy1", {31'h0, busy}, 32'h0);
    do_read(4'd10);

    rst = 1'b1;
    step();
    rst = 1'b0;
    reset_model();
    step();
    do_write(4'd9, 16'h5555, 1'b0);
    do_read(4'd9);

    do_write(4'd12, 16'h1111, 1'b0);
    scrub_req = 1'b1;
    step();
    scrub_req = 1'b0;
    step(); step(); step();
    chk("mid_scrub_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_abort_busy", {31'h0, busy}, 32'h0);
    reset_model();
    step();
    rst = 1'b0;
    step();
    read_all("post_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
